// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg
//   Shared definitions for the UART transmit FIFO slice.
//   - UART_DATA_WIDTH  : byte width of the UART data path.
//   - FIFO_ADDR_WIDTH  : default FIFO address width (depth = 2**FIFO_ADDR_WIDTH).
//   - FIFO_AFULL_LEVEL : default almost-full threshold.
//   - level_reached()  : occupancy threshold helper used for almost_full.
package uart_tx_fifo_pkg;

  localparam int UART_DATA_WIDTH  = 8;
  localparam int FIFO_ADDR_WIDTH  = 4;
  localparam int FIFO_AFULL_LEVEL = 12;

  function automatic logic level_reached(input int unsigned level,
                                         input int unsigned threshold);
    return level >= threshold;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram
//   Simple dual-port storage for the UART TX FIFO: one synchronous write port
//   and one asynchronous read port. The storage array has no reset; the
//   pointer logic in the parent decides which entries are meaningful.
// Ports:
//   clk    in  rising-edge clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address
//   rdata  out read data (combinational from the array)
module uart_fifo_ram
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   AXI4-Stream byte FIFO feeding the UART transmitter. Absorbs bursty host
//   writes and reports its fill level for flow control. First-word
//   fall-through: a byte written at one edge is presented on m_axis right
//   after that edge. Handshake outputs come only from registered state.
//   Optional feature macro: UART_FIFO_FLUSH_EN adds the flush input.
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   synchronous reset, active low
//   s_axis_tdata   in   host write data
//   s_axis_tvalid  in   host write valid
//   s_axis_tready  out  FIFO not full
//   m_axis_tdata   out  head-of-FIFO byte (0 while empty)
//   m_axis_tvalid  out  FIFO not empty
//   m_axis_tready  in   UART TX ready
//   count          out  occupancy, 0..2**ADDR_WIDTH
//   almost_full    out  count >= AFULL_LEVEL (registered)
//   flush          in   (UART_FIFO_FLUSH_EN only) discard all contents
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = UART_DATA_WIDTH,
  parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int AFULL_LEVEL = FIFO_AFULL_LEVEL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full
`ifdef UART_FIFO_FLUSH_EN
  ,
  input  logic                  flush
`endif
);

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic                  full_q, empty_q;
  logic                  full_nxt, empty_nxt;
  logic                  push, pop, flush_req;
  logic [DATA_WIDTH-1:0] rd_data;

`ifdef UART_FIFO_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign push = s_axis_tvalid & ~full_q;
  assign pop  = m_axis_tready & ~empty_q;

  assign s_axis_tready = ~full_q;
  assign m_axis_tvalid = ~empty_q;
  // Forcing zero while empty keeps the output defined even though the
  // storage array itself is never reset.
  assign m_axis_tdata  = empty_q ? '0 : rd_data;

  uart_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (push & ~flush_req),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (s_axis_tdata),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rd_data)
  );

  // Next-pointer computation. A flush discards everything, including any
  // push or pop offered in the same cycle, by snapping rd_ptr onto wr_ptr.
  // The extra pointer MSB distinguishes full from empty when the low bits match.
  always_comb begin
    wr_ptr_nxt = wr_ptr + (ADDR_WIDTH + 1)'(push);
    rd_ptr_nxt = rd_ptr + (ADDR_WIDTH + 1)'(pop);
    if (flush_req) begin
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = wr_ptr;
    end
    count_nxt = wr_ptr_nxt - rd_ptr_nxt;
    empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
    full_nxt  = (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]) &&
                (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]);
  end

  // Pointer, occupancy and flag registers; flags are precomputed from the
  // next pointers so every status output is a plain flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      almost_full <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      count       <= count_nxt;
      full_q      <= full_nxt;
      empty_q     <= empty_nxt;
      almost_full <= level_reached(32'(count_nxt), 32'(AFULL_LEVEL));
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Scoreboard bench for uart_tx_fifo. The reference model is a plain byte
//   queue: accepted writes are appended, and its size is the expected
//   occupancy. A separate monitor pops the queue whenever the DUT completes
//   an output handshake and compares the byte.
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFULL = 12;

`ifdef UART_FIFO_FLUSH_EN
  localparam bit HAS_FLUSH = 1'b1;
`else
  localparam bit HAS_FLUSH = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b1;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [AW:0]   count;
  logic          almost_full;
  logic          flush = 1'b0;

  logic [DW-1:0] exp_q[$];
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .AFULL_LEVEL(AFULL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .count        (count),
    .almost_full  (almost_full)
`ifdef UART_FIFO_FLUSH_EN
    ,
    .flush        (flush)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Status comparison against the model occupancy, taken at the falling edge.
  task automatic checkOutput();
    int occ;
    occ = exp_q.size();
    check("count", 32'(count), 32'(occ));
    check("s_axis_tready", 32'(s_axis_tready), 32'(occ < DEPTH));
    check("m_axis_tvalid", 32'(m_axis_tvalid), 32'(occ > 0));
    check("almost_full", 32'(almost_full), 32'(occ >= AFULL));
    if (occ > 0) check("head_data", 32'(m_axis_tdata), 32'(exp_q[0]));
  endtask

  // One clock of stimulus: check current state, drive the inputs for the
  // next rising edge, and update the model with the write it will accept.
  task automatic applyStimulus(input logic r, input logic v, input logic [DW-1:0] d,
                               input logic rdy, input logic fl, output logic accepted);
    @(negedge clk);
    checkOutput();
    rst_n         = r;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    m_axis_tready = rdy;
    flush         = fl;
    accepted      = 1'b0;
    if (!r || (fl && HAS_FLUSH)) begin
      exp_q.delete();
    end else if (v && exp_q.size() < DEPTH) begin
      exp_q.push_back(d);
      accepted = 1'b1;
    end
  endtask

  // Output monitor: sampled just after the stimulus settles, so it sees the
  // exact handshake the next rising edge will complete.
  always begin
    logic [DW-1:0] expd;
    @(negedge clk);
    #1;
    if (rst_n && !(flush && HAS_FLUSH) && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", 32'(m_axis_tdata), 32'hFFFF_FFFF);
      end else begin
        expd = exp_q.pop_front();
        check("data_out", 32'(m_axis_tdata), 32'(expd));
      end
    end
  end

  initial begin
    logic acc;
    int   pushed;
    int   cyc;

    // Reset held two cycles with a write offered.
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("reset_tdata", 32'(m_axis_tdata), 32'h0);

    // Fill with 0x00..0x0F while the UART side stalls, then offer 0xAA.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, acc);

    // Drain in order.
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Concurrent push/pop at full, then at 15.
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 8'hB0, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 8'hB1, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);

    // Random streaming through pointer wrap.
    pushed = 0;
    cyc    = 0;
    while (pushed < 40 && cyc < 2000) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom),
                    1'($urandom_range(0, 1)), 1'b0, acc);
      if (acc) pushed++;
      cyc++;
    end
    if (pushed < 40) begin
      checks++;
      errors++;
      $display("[TB] FAIL wrap_budget: pushed %0d required 40", pushed);
    end
    for (int i = 0; i < DEPTH + 4; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);

`ifdef UART_FIFO_FLUSH_EN
    // Flush at count 5 with a simultaneous push of 0x55.
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 8'h55, 1'b1, 1'b1, acc);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, acc);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, acc);
`endif

    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, acc);
    @(negedge clk);
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
